// File: rtl/dcache_miss_ctrl_if.sv
// Miss-controller bus bundle: cache-side miss request, memory request/response, refill port.
// The controller uses the master modport; the cache/memory side uses slave.
interface dcache_miss_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              miss_valid;
  logic [1:0]        miss_mode;
  logic [ADDR_W-1:0] miss_addr;
  logic [ADDR_W-1:0] victim_addr;
  logic [DATA_W-1:0] victim_data;
  logic              busy;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic              err;

  modport master (
    input  miss_valid, miss_mode, miss_addr, victim_addr, victim_data,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output busy, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
           fill_valid, fill_addr, fill_data, err
  );

  modport slave (
    output miss_valid, miss_mode, miss_addr, victim_addr, victim_data,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  busy, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
           fill_valid, fill_addr, fill_data, err
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: optional victim write-back, then a single-word refill read,
// with a per-wait timeout that aborts the transaction and pulses err.
module dcache_miss_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              CLK,
  input logic              RESET,
  dcache_miss_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    FILL    = 3'd5
  } state_t;

  // Timeout fires on the edge where the counter would reach TIMEOUT.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              err_q, err_nxt;
  logic [7:0]        wait_cnt;
  logic [ADDR_W-1:0] miss_addr_q, victim_addr_q;
  logic [DATA_W-1:0] victim_data_q, rdata_q;

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.miss_valid) begin
          if (bus.miss_mode == 2'b10)      state_nxt = WB_REQ;
          else if (bus.miss_mode == 2'b01) state_nxt = RD_REQ;
          else                             err_nxt   = 1'b1;
        end
      end
      WB_REQ:  if (bus.mem_req_ready) state_nxt = WB_WAIT;
      WB_WAIT: begin
        if (bus.mem_rsp_valid) state_nxt = RD_REQ;
        else if (wait_cnt >= TIMEOUT_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      RD_REQ:  if (bus.mem_req_ready) state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (bus.mem_rsp_valid) state_nxt = FILL;
        else if (wait_cnt >= TIMEOUT_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      FILL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      err_q         <= 1'b0;
      wait_cnt      <= 8'd0;
      miss_addr_q   <= '0;
      victim_addr_q <= '0;
      victim_data_q <= '0;
      rdata_q       <= '0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (state == IDLE && bus.miss_valid) begin
        miss_addr_q   <= bus.miss_addr;
        victim_addr_q <= bus.victim_addr;
        victim_data_q <= bus.victim_data;
      end
      // Held at zero while requesting, so each wait phase starts from a clean count.
      if (state == WB_REQ || state == RD_REQ)
        wait_cnt <= 8'd0;
      else if ((state == WB_WAIT || state == RD_WAIT) && !bus.mem_rsp_valid && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
      if (state == RD_WAIT && bus.mem_rsp_valid)
        rdata_q <= bus.mem_rsp_data;
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.mem_req_valid = (state == WB_REQ) || (state == RD_REQ);
  assign bus.mem_req_we    = (state == WB_REQ);
  assign bus.mem_req_addr  = (state == WB_REQ) ? victim_addr_q :
                             (state == RD_REQ) ? miss_addr_q : '0;
  assign bus.mem_req_wdata = (state == WB_REQ) ? victim_data_q : '0;
  assign bus.fill_valid    = (state == FILL);
  assign bus.fill_addr     = (state == FILL) ? miss_addr_q : '0;
  assign bus.fill_data     = (state == FILL) ? rdata_q : '0;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: vector table for whole transactions plus
// hand-written backpressure, timeout, response-vs-timeout and mid-transaction reset sequences.
module tb_dcache_miss_ctrl;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   total = 0;
  int   bad   = 0;

  dcache_miss_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dcache_miss_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.master)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] maddr;
    logic [31:0] vaddr;
    logic [31:0] vdata;
    logic [31:0] rdata;
    bit          exp_err;     // err pulse seen right after the sampling edge
    int          exp_nwr;     // number of write handshakes
    int          exp_fill_k;  // negedge index after miss sampling edge N where fill_valid is high; -1 none
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_ctl"}, 64'({bus.busy, bus.mem_req_valid, bus.mem_req_we, bus.fill_valid, bus.err}), 64'd0);
    check({name, "_req"}, {bus.mem_req_addr, bus.mem_req_wdata}, 64'd0);
    check({name, "_fill"}, {bus.fill_addr, bus.fill_data}, 64'd0);
  endtask

  // Called at a negedge; presents the miss for the next edge and plays a memory that
  // accepts immediately and responds in the cycle after each handshake.
  task automatic run_vec(input vec_t v, input int idx);
    int nwr = 0, nrd = 0, nfill = 0;
    int fill_k = -1, err_k = -1, wr_k = -1, rd_k = -1, ack_k = -1;
    logic [31:0] wa = 0, wd = 0, ra = 0, fa = 0, fd = 0;
    bit hs_last = 0, hs_we_last = 0, busy_ever = 0;
    logic busy_after = 1'bx;
    string tag;
    tag = $sformatf("v%0d", idx);
    bus.miss_valid  = 1'b1;
    bus.miss_mode   = v.mode;
    bus.miss_addr   = v.maddr;
    bus.victim_addr = v.vaddr;
    bus.victim_data = v.vdata;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      bus.miss_valid    = 1'b0;
      bus.mem_rsp_valid = hs_last;
      bus.mem_rsp_data  = hs_we_last ? 32'h0BAD_0BAD : v.rdata;
      if (hs_last && hs_we_last && ack_k < 0) ack_k = k;
      if (fill_k >= 0 && k == fill_k + 1) busy_after = bus.busy;
      if (bus.busy) busy_ever = 1'b1;
      hs_last = bus.mem_req_valid && bus.mem_req_ready;
      if (hs_last) begin
        hs_we_last = bus.mem_req_we;
        if (bus.mem_req_we) begin
          nwr++; wa = bus.mem_req_addr; wd = bus.mem_req_wdata; wr_k = k;
        end else begin
          nrd++; ra = bus.mem_req_addr; rd_k = k;
        end
      end
      if (bus.fill_valid) begin
        nfill++; fill_k = k; fa = bus.fill_addr; fd = bus.fill_data;
      end
      if (bus.err && err_k < 0) err_k = k;
    end
    bus.mem_rsp_valid = 1'b0;
    check({tag, "_err_k"}, 64'(err_k), v.exp_err ? 64'd0 : 64'(-1));
    check({tag, "_nwr"}, 64'(nwr), 64'(v.exp_nwr));
    check({tag, "_nrd"}, 64'(nrd), (v.exp_fill_k >= 0) ? 64'd1 : 64'd0);
    check({tag, "_nfill"}, 64'(nfill), (v.exp_fill_k >= 0) ? 64'd1 : 64'd0);
    check({tag, "_fill_k"}, 64'(fill_k), 64'(v.exp_fill_k));
    if (v.exp_fill_k >= 0) begin
      check({tag, "_fill_addr"}, 64'(fa), 64'(v.maddr));
      check({tag, "_fill_data"}, 64'(fd), 64'(v.rdata));
      check({tag, "_rd_addr"}, 64'(ra), 64'(v.maddr));
      check({tag, "_busy_after"}, 64'(busy_after), 64'd0);
    end
    if (v.exp_nwr > 0) begin
      check({tag, "_wr_addr"}, 64'(wa), 64'(v.vaddr));
      check({tag, "_wr_data"}, 64'(wd), 64'(v.vdata));
      check({tag, "_wb_before_rd"}, 64'(wr_k < ack_k && ack_k < rd_k), 64'd1);
    end
    if (v.exp_err) check({tag, "_busy_ever"}, 64'(busy_ever), 64'd0);
  endtask

  // Mode-01 miss with no or late response; TIMEOUT is 4 in this bench.
  task automatic run_timeout(input string tag, input int rsp_k, input int exp_err_k,
                             input int exp_fill_k);
    int err_k = -1, fill_k = -1;
    logic busy_end;
    bus.miss_valid = 1'b1;
    bus.miss_mode  = 2'b01;
    bus.miss_addr  = 32'h0000_9000;
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      bus.miss_valid    = 1'b0;
      bus.mem_rsp_valid = (k == rsp_k);
      bus.mem_rsp_data  = 32'h7777_1111;
      if (bus.err && err_k < 0) err_k = k;
      if (bus.fill_valid && fill_k < 0) fill_k = k;
    end
    bus.mem_rsp_valid = 1'b0;
    busy_end = bus.busy;
    check({tag, "_err_k"}, 64'(err_k), 64'(exp_err_k));
    check({tag, "_fill_k"}, 64'(fill_k), 64'(exp_fill_k));
    check({tag, "_busy_end"}, 64'(busy_end), 64'd0);
  endtask

  initial begin
    bit stable;
    bit any_out;

    // miss at edge N: mode 01 fills after edge N+2 (cycle N+3), mode 10 after edge N+4 (cycle N+5)
    vecs[0] = '{mode: 2'b01, maddr: 32'h0000_1040, vaddr: 32'h0000_0000, vdata: 32'h0,
                rdata: 32'hDEAD_BEEF, exp_err: 1'b0, exp_nwr: 0, exp_fill_k: 2};
    vecs[1] = '{mode: 2'b10, maddr: 32'h0000_3040, vaddr: 32'h0000_2040, vdata: 32'h1234_5678,
                rdata: 32'hCAFE_F00D, exp_err: 1'b0, exp_nwr: 1, exp_fill_k: 4};
    vecs[2] = '{mode: 2'b00, maddr: 32'h0000_4040, vaddr: 32'h0000_5040, vdata: 32'h1111_2222,
                rdata: 32'h0, exp_err: 1'b1, exp_nwr: 0, exp_fill_k: -1};
    vecs[3] = '{mode: 2'b11, maddr: 32'h0000_6040, vaddr: 32'h0000_7040, vdata: 32'h3333_4444,
                rdata: 32'h0, exp_err: 1'b1, exp_nwr: 0, exp_fill_k: -1};
    vecs[4] = '{mode: 2'b01, maddr: 32'hFFFF_FFFC, vaddr: 32'hAAAA_0000, vdata: 32'h5555_5555,
                rdata: 32'h0000_0001, exp_err: 1'b0, exp_nwr: 0, exp_fill_k: 2};

    bus.miss_valid    = 1'b0;
    bus.miss_mode     = 2'b00;
    bus.miss_addr     = '0;
    bus.victim_addr   = '0;
    bus.victim_data   = '0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;

    repeat (3) @(negedge CLK);
    check_idle("reset");

    // Release and present the first miss together: it must be taken on the very next edge.
    RESET = 1'b1;
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Backpressure: request held stable for 10 cycles, a second miss in the window is ignored.
    bus.mem_req_ready = 1'b0;
    bus.miss_valid    = 1'b1;
    bus.miss_mode     = 2'b01;
    bus.miss_addr     = 32'h0000_5540;
    @(negedge CLK);
    bus.miss_valid = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(bus.mem_req_valid === 1'b1 && bus.mem_req_we === 1'b0 &&
            bus.mem_req_addr === 32'h0000_5540)) stable = 1'b0;
      bus.miss_valid = (i == 3);
      if (i == 3) begin
        bus.miss_mode   = 2'b10;
        bus.miss_addr   = 32'h0000_7780;
        bus.victim_addr = 32'h0000_8880;
        bus.victim_data = 32'h9999_9999;
      end
      @(negedge CLK);
    end
    check("bp_stable", 64'(stable), 64'd1);
    bus.mem_req_ready = 1'b1;
    @(negedge CLK);
    check("bp_req_dropped", 64'({bus.mem_req_valid, bus.busy}), 64'b01);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hA5A5_5A5A;
    @(negedge CLK);
    bus.mem_rsp_valid = 1'b0;
    check("bp_fill_valid", 64'(bus.fill_valid), 64'd1);
    check("bp_fill_addr", 64'(bus.fill_addr), 64'h0000_5540);
    check("bp_fill_data", 64'(bus.fill_data), 64'hA5A5_5A5A);
    @(negedge CLK);
    check("bp_busy_after", 64'(bus.busy), 64'd0);

    // RD_WAIT entered at edge N+1: timeout err after edge N+5; response on that same edge wins.
    run_timeout("to_none", -1, 5, -1);
    run_timeout("to_race", 4, -1, 5);

    // Reset while waiting for the write acknowledge, then a stray response after release.
    bus.miss_valid  = 1'b1;
    bus.miss_mode   = 2'b10;
    bus.miss_addr   = 32'h0000_3040;
    bus.victim_addr = 32'h0000_2040;
    bus.victim_data = 32'h1234_5678;
    @(negedge CLK);
    bus.miss_valid = 1'b0;
    @(negedge CLK);
    check("rst_in_wb_wait", 64'({bus.busy, bus.mem_req_valid}), 64'b10);
    RESET = 1'b0;
    #1;
    check_idle("rst_mid");
    @(negedge CLK);
    RESET = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hFFFF_0000;
    any_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (bus.busy || bus.mem_req_valid || bus.fill_valid || bus.err) any_out = 1'b1;
    end
    bus.mem_rsp_valid = 1'b0;
    check("rst_stray_rsp", 64'(any_out), 64'd0);
    check_idle("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_miss_ctrl.md
DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL provide parameter DATA_W, default 32, cache data word width.
REQ-003 SHALL provide parameter TIMEOUT, default 255, maximum cycles to wait for a memory response (8-bit counter, 1..255).
REQ-004 CLK  input  1  clock; all state changes on rising edge.
REQ-005 RESET  input  1  reset, asynchronous, active-low.
REQ-006 miss_valid  input  1  cache miss request, sampled in IDLE only.
REQ-007 miss_mode  input  2  01 = refill only; 10 = write back victim, then refill; 00/11 illegal.
REQ-008 miss_addr  input  ADDR_W  refill address.
REQ-009 victim_addr  input  ADDR_W  write-back address.
REQ-010 victim_data  input  DATA_W  write-back data.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 mem_req_valid / mem_req_ready  output / input  1 / 1  memory request handshake.
REQ-013 mem_req_we  output  1  1 = write, 0 = read.
REQ-014 mem_req_addr / mem_req_wdata  output  ADDR_W / DATA_W  request address and write data.
REQ-015 mem_rsp_valid / mem_rsp_data  input  1 / DATA_W  memory response: write acknowledge or read data.
REQ-016 fill_valid  output  1  one-cycle refill strobe to the cache array write port.
REQ-017 fill_addr / fill_data  output  ADDR_W / DATA_W  refill address and data, valid with fill_valid.
REQ-018 err  output  1  one-cycle pulse on timeout or illegal mode.

Function
REQ-019 States SHALL be IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT and FILL.
REQ-020 IDLE, miss_valid=1: SHALL latch miss_addr, victim_addr and victim_data, then go to WB_REQ if mode=10, RD_REQ if mode=01; any other mode SHALL pulse err the next cycle and remain in IDLE.
REQ-021 miss_valid while busy SHALL be ignored with no side effect; the cache re-issues the request.
REQ-022 WB_REQ SHALL drive mem_req_valid=1, we=1, addr and wdata from the victim latches, holding them stable until mem_req_ready; the handshake cycle SHALL move to WB_WAIT.
REQ-023 RD_REQ SHALL drive mem_req_valid=1, we=0, addr from the latched miss_addr; the handshake cycle SHALL move to RD_WAIT.
REQ-024 mem_req_valid SHALL be 0 in every other state and SHALL NOT drop before ready once asserted.
REQ-025 WB_WAIT, mem_rsp_valid=1: SHALL go to RD_REQ; write-back and refill SHALL NEVER be outstanding together.
REQ-026 RD_WAIT, mem_rsp_valid=1: SHALL register mem_rsp_data and go to FILL.
REQ-027 FILL SHALL last exactly one cycle with fill_valid=1, fill_addr equal to the latched miss_addr and fill_data equal to the registered data, then return to IDLE.
REQ-028 Minimum refill latency, with ready and rsp each one cycle after request: miss_valid sampled at edge N -> fill_valid high in cycle N+3 (mode 01) or N+5 (mode 10).
REQ-029 mem_rsp_valid outside WB_WAIT/RD_WAIT SHALL be ignored.
REQ-030 Wait counter SHALL clear on entry to WB_WAIT/RD_WAIT and increment each cycle without a response.
REQ-031 On reaching TIMEOUT the FSM SHALL pulse err and return to IDLE; a timed-out read SHALL produce no fill_valid.
REQ-032 mem_rsp_valid in the same cycle the counter reaches TIMEOUT SHALL take priority; no err.
REQ-033 Wait counter SHALL saturate and never wrap.

Reset
REQ-034 RESET low SHALL immediately force IDLE with busy, mem_req_valid, mem_req_we, fill_valid and err = 0; all address/data outputs, latches and counter = 0.
REQ-035 Reset mid-transaction SHALL abandon it; a late mem_rsp_valid after release SHALL be ignored per REQ-029.
REQ-036 First miss_valid SHALL be accepted on the first rising edge after RESET deasserts.

Verification
REQ-037 Mode 01 at 0x0000_1040, ready and rsp one cycle after request, rsp_data 0xDEAD_BEEF -> single read at 0x1040; fill_valid at N+3 with fill_data 0xDEADBEEF; busy low the following cycle.
REQ-038 Mode 10, victim 0x0000_2040 / 0x1234_5678, miss 0x0000_3040 -> write 0x2040 completes and is acknowledged before read 0x3040 is issued; exactly one fill at 0x3040.
REQ-039 mem_req_ready held low 10 cycles in RD_REQ -> valid, we and addr stable all 10 cycles; second miss_valid in that window ignored.
REQ-040 TIMEOUT=4, no response in RD_WAIT -> err pulse 4 cycles after RD_WAIT entry, return to IDLE, no fill_valid.
REQ-041 Modes 00 and 11 -> err pulse, no memory request, busy stays 0.
REQ-042 RESET asserted in WB_WAIT, then stray mem_rsp_valid after release -> all outputs 0, no fill_valid.
